// File: rtl/bep_word_deframer.sv
// Purpose: BEP word deframer. Hunts for a sync pattern in the decoded bit stream, then assembles the payload word.
// Latency: word_data/word_valid appear one cycle after the strobe that completes the frame.
// Backpressure: none; the bit stream cannot be stalled and each word is presented as a single-cycle pulse.
//
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   decoded_data, decoded_clock  : bit value and level bit clock from the biphase decoder
//   word_data, word_valid        : last completed word (MSB = first payload bit) and its update pulse
//   sync_locked                  : high while collecting payload (and parity) bits
//   frame_error                  : pulse when a locked frame is abandoned on bit timeout
//   parity_error                 : pulse alongside word_valid on even-parity mismatch
// Build option: define BEP_DEFRAMER_PARITY_EN to expect one even-parity bit after the payload.
// Without it, parity_error is tied low.

module bep_word_deframer #(
    parameter int                    SYNC_WIDTH     = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN   = SYNC_WIDTH'(8'hE2),
    parameter int                    WORD_WIDTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  decoded_data,
    input  logic                  decoded_clock,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    output logic                  sync_locked,
    output logic                  frame_error,
    output logic                  parity_error
);

    localparam int CNT_W  = $clog2(WORD_WIDTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    prev_clk_q;
    logic [SYNC_WIDTH-1:0]   sync_sr_q;
    logic [WORD_WIDTH-1:0]   data_sr_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [IDLE_W-1:0]       idle_cnt_q;
    logic [WORD_WIDTH-1:0]   word_data_q;
    logic                    word_valid_q;
    logic                    frame_error_q;

    logic                    strobe;
    logic [SYNC_WIDTH-1:0]   sync_shift_d;
    logic [WORD_WIDTH:0]     data_ext;
    logic [WORD_WIDTH-1:0]   data_shift_d;

    // Rising edge of the decoder's bit clock; the data bit is sampled in the same cycle.
    assign strobe       = decoded_clock & ~prev_clk_q;
    assign sync_shift_d = {sync_sr_q[SYNC_WIDTH-2:0], decoded_data};
    // Widened concatenation keeps the MSB-first shift legal for WORD_WIDTH == 1.
    assign data_ext     = {data_sr_q, decoded_data};
    assign data_shift_d = data_ext[WORD_WIDTH-1:0];

`ifdef BEP_DEFRAMER_PARITY_EN
    logic parity_error_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            // Reset high so a bit clock held high through reset release is not a strobe.
            prev_clk_q    <= 1'b1;
            sync_sr_q     <= '0;
            data_sr_q     <= '0;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            word_data_q   <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef BEP_DEFRAMER_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            prev_clk_q    <= decoded_clock;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef BEP_DEFRAMER_PARITY_EN
            parity_error_q <= 1'b0;
`endif
            if (state_q == ST_HUNT) begin
                idle_cnt_q <= '0;
                if (strobe) begin
                    if (sync_shift_d == SYNC_PATTERN) begin
                        // Cleared on lock so every later return to HUNT starts from an empty history.
                        sync_sr_q  <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_RECEIVE;
                    end else begin
                        sync_sr_q  <= sync_shift_d;
                    end
                end
            end else if (!strobe) begin
                // Locked and idle: abandon the frame when the idle run reaches the limit.
                if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_q    <= '0;
                    frame_error_q <= 1'b1;
                    state_q       <= ST_HUNT;
                end else begin
                    idle_cnt_q    <= idle_cnt_q + IDLE_W'(1);
                end
            end else begin
                idle_cnt_q <= '0;
                if (state_q == ST_RECEIVE) begin
                    data_sr_q <= data_shift_d;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
`ifdef BEP_DEFRAMER_PARITY_EN
                        state_q      <= ST_PARITY;
`else
                        word_data_q  <= data_shift_d;
                        word_valid_q <= 1'b1;
                        state_q      <= ST_HUNT;
`endif
                    end
                end
`ifdef BEP_DEFRAMER_PARITY_EN
                else begin
                    // Parity bit: even parity over payload plus this bit must be zero.
                    word_data_q    <= data_sr_q;
                    word_valid_q   <= 1'b1;
                    parity_error_q <= (^data_sr_q) ^ decoded_data;
                    state_q        <= ST_HUNT;
                end
`endif
            end
        end
    end

    assign word_data   = word_data_q;
    assign word_valid  = word_valid_q;
    assign frame_error = frame_error_q;
    assign sync_locked = (state_q != ST_HUNT);
`ifdef BEP_DEFRAMER_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
